dvp_frame_ctrl: RTL and testbench
=================================

Name: dvp_frame_ctrl

Overview:
- Parametrised successor to the DVP capture gate. Sits between the pixel-info FIFO (camera clock-domain crossing already done) and the gray-scale stage.
- Frames DVP byte samples using their VSYNC/HSYNC flags.
- Packs bytes MSB-first into RGB pixels and tags start-of-frame and end-of-line.
- Checks line length and frame height against parameters. Supports continuous and single-frame capture with stall-on-backpressure.

Parameters:
- DVP_DATA_W, 8: DVP data bus width.
- PXL_INFO_W, DVP_DATA_W+2: FIFO entry width, laid out as {VSYNC, HSYNC, DATA}.
- RGB_PXL_W, 16: output pixel width. Must be an integer multiple N = RGB_PXL_W/DVP_DATA_W, with N >= 1.
- FRAME_W, 640: expected pixels per line.
- FRAME_H, 480: expected lines per frame.
- COL_CNT_W, 12: byte-per-line counter width. Must hold FRAME_W*N.
- ROW_CNT_W, 10: line counter width. Must hold FRAME_H.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pxl_info_i  in  PXL_INFO_W  FIFO entry: [DVP_DATA_W+1]=VSYNC, [DVP_DATA_W]=HSYNC, low bits=data
- pxl_info_vld_i  in  1  FIFO entry valid
- pxl_info_rdy_o  out  1  entry consumed this cycle when high together with vld
- dcr_cam_start_i  in  1  capture enable (level)
- dcr_single_frame_i  in  1  1=single-frame mode, sampled on leaving IDLE
- dcr_err_clr_i  in  1  clears sticky error flags
- rgb_pxl_o  out  RGB_PXL_W  packed pixel
- rgb_pxl_vld_o  out  1  output valid
- rgb_pxl_rdy_i  in  1  downstream ready
- rgb_sof_o  out  1  qualifies rgb_pxl_o as first pixel of frame
- rgb_eol_o  out  1  qualifies rgb_pxl_o as last pixel of line
- frame_done_o  out  1  one-cycle pulse at frame end
- line_err_o  out  1  sticky: a line had a length other than FRAME_W
- frame_err_o  out  1  sticky: a frame had a line count other than FRAME_H
- busy_o  out  1  state is not IDLE

Behaviour:

Reset:
- All outputs are 0. State is IDLE. Counters, byte index, and SOF-pending are 0.

Entry classes (evaluated on vld&rdy):
- VSYNC=1: frame marker. Data is ignored.
- VSYNC=0, HSYNC=1: pixel byte.
- Both 0: blanking. A line ends on the first blanking or VSYNC entry that follows a pixel byte.

States:
- IDLE: rdy_o=0. Leaves to WAIT_VS when dcr_cam_start_i=1; latches single-frame mode on this transition.
- WAIT_VS: rdy_o=1 and all entries are discarded. On a VSYNC entry: go to ACTIVE, clear counters, set SOF-pending.
- ACTIVE, pixel byte:
  - Shifted into the pack register MSB-first; byte index increments.
  - On byte N, the pixel is complete. It loads into the output register with sof=SOF-pending; SOF-pending then clears.
  - The column counter increments per byte.
- ACTIVE, line end:
  - The last loaded pixel gets eol=1. If that pixel is still in the output register, set its eol flag.
  - If byte count != FRAME_W*N, or byte index != 0, set line_err. Reset the byte index and column counter.
  - Row counter increments.
- ACTIVE, VSYNC entry (after line-end processing):
  - If row != FRAME_H, set frame_err. Pulse frame_done_o.
  - Single mode: go to DONE.
  - Continuous mode: if start=1, restart ACTIVE with counters cleared and SOF-pending set; if start=0, go to IDLE.
- DONE: rdy_o=0 and the output register drains. Goes to IDLE when dcr_cam_start_i=0 and rgb_pxl_vld_o=0.
- dcr_cam_start_i falling while ACTIVE: the current frame completes, then the block goes to IDLE at the next VSYNC.

Output handshake:
- Single output register. rgb_pxl_vld_o holds, with data stable, until rgb_pxl_rdy_i.
- Latency: a pixel is valid 1 cycle after its last byte is accepted.
- Back-to-back throughput is one pixel per N accepted bytes.

Stall:
- In ACTIVE, rdy_o drops only when the entry is a pixel byte that would complete a pixel, and the output register is full and not being drained this cycle.
- A drain and a load in the same cycle are allowed.
- When N=1, every pixel byte is a completing byte.

Errors:
- line_err and frame_err are sticky.
- dcr_err_clr_i clears them. If a clear and a new error occur in the same cycle, the error wins.

Reset mid-frame:
- Returns to IDLE. Any in-flight pixel is discarded.

Optional Feature:
- DVP_DROP_ON_STALL_EN defined:
  - rdy_o is always 1 in ACTIVE.
  - A pixel completing while the output register is full and not drained is dropped.
  - Adds output port ovf_err_o, sticky and cleared by dcr_err_clr_i.
- DVP_DROP_ON_STALL_EN not defined: stall behaviour as above, and the port ovf_err_o does not exist.

Test Plan:
- Reset, then start=1 with a 2x2 frame (FRAME_W=2, FRAME_H=2, N=2). Bytes per frame: VS, 4 bytes HS, blank, 4 bytes HS, blank, VS. Required: 4 pixels, e.g. bytes A5,3C -> 16'hA53C. sof on pixel 0, eol on pixels 1 and 3, frame_done pulse, no errors.
- rgb_pxl_rdy_i=0 for 10 cycles mid-line. Required: rdy_o drops on the completing byte, no pixel is lost or duplicated, and data holds stable.
- Line of 3 bytes (N=2). Required: line_err=1 after the blank; frame_err stays 0. Asserting dcr_err_clr_i returns line_err to 0.
- Single mode, two VSYNC-delimited frames sent. Required: only the first frame is output, the state is DONE with rdy_o=0, and IDLE follows after start drops.
- Frame of 3 lines with FRAME_H=2. Required: frame_err=1 at the closing VSYNC. A byte arriving before the first VSYNC in WAIT_VS is discarded, with no output.
- rst asserted mid-line. Required: next cycle all outputs are 0 and busy_o=0. A restart captures a clean frame with sof on its first pixel.

Source files
------------

// File: rtl/dvp_frame_ctrl.sv
// rtl/dvp_frame_ctrl.sv - DVP byte framer/packer with line/frame checks; optional DVP_DROP_ON_STALL_EN drops pixels instead of stalling
module dvp_frame_ctrl #(
    parameter int DVP_DATA_W = 8,
    parameter int PXL_INFO_W = DVP_DATA_W + 2,
    parameter int RGB_PXL_W  = 16,
    parameter int FRAME_W    = 640,
    parameter int FRAME_H    = 480,
    parameter int COL_CNT_W  = 12,
    parameter int ROW_CNT_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PXL_INFO_W-1:0] pxl_info_i,
    input  logic                  pxl_info_vld_i,
    output logic                  pxl_info_rdy_o,
    input  logic                  dcr_cam_start_i,
    input  logic                  dcr_single_frame_i,
    input  logic                  dcr_err_clr_i,
    output logic [RGB_PXL_W-1:0]  rgb_pxl_o,
    output logic                  rgb_pxl_vld_o,
    input  logic                  rgb_pxl_rdy_i,
    output logic                  rgb_sof_o,
    output logic                  rgb_eol_o,
    output logic                  frame_done_o,
    output logic                  line_err_o,
    output logic                  frame_err_o,
`ifdef DVP_DROP_ON_STALL_EN
    output logic                  ovf_err_o,
`endif
    output logic                  busy_o
);

    // Bytes per pixel and the derived counter limits.
    localparam int N     = RGB_PXL_W / DVP_DATA_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(N - 1);
    localparam logic [COL_CNT_W-1:0] LINE_BYTES  = COL_CNT_W'(FRAME_W * N);
    localparam logic [ROW_CNT_W-1:0] FRAME_LINES = ROW_CNT_W'(FRAME_H);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VS,
        ST_ACTIVE,
        ST_DONE
    } state_t;

    state_t                 state_q;
    logic                   single_q;
    logic [IDX_W-1:0]       byte_idx_q;
    logic [COL_CNT_W-1:0]   col_cnt_q;
    logic [ROW_CNT_W-1:0]   row_cnt_q;
    logic                   in_line_q;
    logic                   sof_pend_q;
    logic [RGB_PXL_W-1:0]   pack_q;
    logic                   frame_done_q;

    logic                   out_vld_q;
    logic [RGB_PXL_W-1:0]   out_data_q;
    logic                   out_sof_q;
    logic                   out_eol_q;

    logic                   line_err_q;
    logic                   frame_err_q;

    // Entry decode: {VSYNC, HSYNC, DATA}.
    logic                   ent_vs;
    logic                   ent_hs;
    logic [DVP_DATA_W-1:0]  ent_data;
    logic                   ent_pix;

    assign ent_vs   = pxl_info_i[DVP_DATA_W+1];
    assign ent_hs   = pxl_info_i[DVP_DATA_W];
    assign ent_data = pxl_info_i[DVP_DATA_W-1:0];
    assign ent_pix  = ~ent_vs & ent_hs;

    // Pack register shifted left by one byte with the new byte in the LSBs.
    logic [RGB_PXL_W+DVP_DATA_W-1:0] pack_wide;
    logic [RGB_PXL_W-1:0]            pack_next;

    assign pack_wide = {pack_q, ent_data};
    assign pack_next = pack_wide[RGB_PXL_W-1:0];

    logic completing;
    logic out_drain;
    logic out_blocked;
    logic stall;

    assign completing  = (byte_idx_q == LAST_IDX);
    assign out_drain   = out_vld_q & rgb_pxl_rdy_i;
    assign out_blocked = out_vld_q & ~rgb_pxl_rdy_i;
    assign stall       = ent_pix & completing & out_blocked;

    // Ready: discard everything while hunting for VSYNC, back-pressure only on a blocked completing byte.
    always_comb begin
        pxl_info_rdy_o = 1'b0;
        case (state_q)
            ST_WAIT_VS: pxl_info_rdy_o = 1'b1;
`ifdef DVP_DROP_ON_STALL_EN
            ST_ACTIVE:  pxl_info_rdy_o = 1'b1;
`else
            ST_ACTIVE:  pxl_info_rdy_o = ~stall;
`endif
            default:    pxl_info_rdy_o = 1'b0;
        endcase
    end

    logic xfer;
    logic act_xfer;
    logic pix_acc;
    logic pix_done;
    logic pix_load;
    logic line_end;
    logic frame_end;

    assign xfer      = pxl_info_vld_i & pxl_info_rdy_o;
    assign act_xfer  = xfer & (state_q == ST_ACTIVE);
    assign pix_acc   = act_xfer & ent_pix;
    assign pix_done  = pix_acc & completing;
    assign line_end  = act_xfer & ~ent_pix & in_line_q;
    assign frame_end = act_xfer & ent_vs;

`ifdef DVP_DROP_ON_STALL_EN
    logic pix_drop;
    assign pix_load = pix_done & ~out_blocked;
    assign pix_drop = pix_done & out_blocked;
`else
    assign pix_load = pix_done;
`endif

    // Row count as it stands once a pending line end has been accounted for.
    logic [COL_CNT_W-1:0] col_plus;
    logic [ROW_CNT_W-1:0] row_plus;
    logic [ROW_CNT_W-1:0] row_next;
    logic                 line_bad;

    assign col_plus = (col_cnt_q == '1) ? col_cnt_q : col_cnt_q + COL_CNT_W'(1);
    assign row_plus = (row_cnt_q == '1) ? row_cnt_q : row_cnt_q + ROW_CNT_W'(1);
    assign row_next = in_line_q ? row_plus : row_cnt_q;
    assign line_bad = (col_cnt_q != LINE_BYTES) | (byte_idx_q != '0);

    logic line_err_set;
    logic frame_err_set;

    assign line_err_set  = line_end & line_bad;
    assign frame_err_set = frame_end & (row_next != FRAME_LINES);

    // Capture FSM: framing, packing counters, SOF tracking and frame-end decisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            single_q     <= 1'b0;
            byte_idx_q   <= '0;
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            in_line_q    <= 1'b0;
            sof_pend_q   <= 1'b0;
            pack_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (dcr_cam_start_i) begin
                        state_q  <= ST_WAIT_VS;
                        single_q <= dcr_single_frame_i;
                    end
                end
                ST_WAIT_VS: begin
                    if (xfer && ent_vs) begin
                        state_q    <= ST_ACTIVE;
                        byte_idx_q <= '0;
                        col_cnt_q  <= '0;
                        row_cnt_q  <= '0;
                        in_line_q  <= 1'b0;
                        sof_pend_q <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (pix_acc) begin
                        pack_q     <= pack_next;
                        byte_idx_q <= completing ? '0 : byte_idx_q + IDX_W'(1);
                        col_cnt_q  <= col_plus;
                        in_line_q  <= 1'b1;
                        if (pix_load) begin
                            sof_pend_q <= 1'b0;
                        end
                    end
                    if (line_end) begin
                        byte_idx_q <= '0;
                        col_cnt_q  <= '0;
                        row_cnt_q  <= row_plus;
                        in_line_q  <= 1'b0;
                    end
                    if (frame_end) begin
                        frame_done_q <= 1'b1;
                        byte_idx_q   <= '0;
                        col_cnt_q    <= '0;
                        row_cnt_q    <= '0;
                        in_line_q    <= 1'b0;
                        if (single_q) begin
                            state_q <= ST_DONE;
                        end else if (dcr_cam_start_i) begin
                            sof_pend_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!dcr_cam_start_i && !out_vld_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Single output register: drain and load may coincide; a late line end marks the held pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_sof_q  <= 1'b0;
            out_eol_q  <= 1'b0;
        end else begin
            if (out_drain) begin
                out_vld_q <= 1'b0;
                out_sof_q <= 1'b0;
                out_eol_q <= 1'b0;
            end
            if (pix_load) begin
                out_vld_q  <= 1'b1;
                out_data_q <= pack_next;
                out_sof_q  <= sof_pend_q;
                out_eol_q  <= 1'b0;
            end else if (line_end && out_blocked) begin
                out_eol_q <= 1'b1;
            end
        end
    end

    // Sticky error flags; a new error in the same cycle beats the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (line_err_set) begin
                line_err_q <= 1'b1;
            end else if (dcr_err_clr_i) begin
                line_err_q <= 1'b0;
            end
            if (frame_err_set) begin
                frame_err_q <= 1'b1;
            end else if (dcr_err_clr_i) begin
                frame_err_q <= 1'b0;
            end
        end
    end

`ifdef DVP_DROP_ON_STALL_EN
    logic ovf_err_q;

    // Sticky overflow flag for pixels dropped against a full output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err_q <= 1'b0;
        end else if (pix_drop) begin
            ovf_err_q <= 1'b1;
        end else if (dcr_err_clr_i) begin
            ovf_err_q <= 1'b0;
        end
    end

    assign ovf_err_o = ovf_err_q;
`endif

    // The held pixel is also the line's last one when the line end arrives while it is still presented.
    assign rgb_pxl_o     = out_data_q;
    assign rgb_pxl_vld_o = out_vld_q;
    assign rgb_sof_o     = out_sof_q;
    assign rgb_eol_o     = out_eol_q | (line_end & out_vld_q);
    assign frame_done_o  = frame_done_q;
    assign line_err_o    = line_err_q;
    assign frame_err_o   = frame_err_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dvp_frame_ctrl.sv
// tb/tb_dvp_frame_ctrl.sv - directed self-checking bench for dvp_frame_ctrl (2x2 frame, N=2)
module tb_dvp_frame_ctrl;

    logic        clk;
    logic        rst;
    logic [9:0]  pxl_info;
    logic        pxl_vld;
    logic        pxl_rdy;
    logic        start;
    logic        single;
    logic        err_clr;
    logic [15:0] rgb_pxl;
    logic        rgb_vld;
    logic        rgb_rdy;
    logic        rgb_sof;
    logic        rgb_eol;
    logic        frame_done;
    logic        line_err;
    logic        frame_err;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int fd_cnt = 0;
    int fd_base;

    logic [17:0] got_q[$];
    logic [17:0] exp_q[$];

    dvp_frame_ctrl #(
        .DVP_DATA_W(8),
        .PXL_INFO_W(10),
        .RGB_PXL_W (16),
        .FRAME_W   (2),
        .FRAME_H   (2),
        .COL_CNT_W (12),
        .ROW_CNT_W (10)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .pxl_info_i        (pxl_info),
        .pxl_info_vld_i    (pxl_vld),
        .pxl_info_rdy_o    (pxl_rdy),
        .dcr_cam_start_i   (start),
        .dcr_single_frame_i(single),
        .dcr_err_clr_i     (err_clr),
        .rgb_pxl_o         (rgb_pxl),
        .rgb_pxl_vld_o     (rgb_vld),
        .rgb_pxl_rdy_i     (rgb_rdy),
        .rgb_sof_o         (rgb_sof),
        .rgb_eol_o         (rgb_eol),
        .frame_done_o      (frame_done),
        .line_err_o        (line_err),
        .frame_err_o       (frame_err),
        .busy_o            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: record every transfer as {sof, eol, data} and count frame_done pulses.
    always @(negedge clk) begin
        if (rgb_vld && rgb_rdy) got_q.push_back({rgb_sof, rgb_eol, rgb_pxl});
        if (frame_done) fd_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic vs, input logic hs, input logic [7:0] d);
        int t;
        pxl_info = {vs, hs, d};
        pxl_vld  = 1'b1;
        t = 0;
        @(negedge clk);
        while (pxl_rdy !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("accept", 32'(pxl_rdy), 32'd1);
        @(posedge clk);
        #1;
        pxl_vld = 1'b0;
    endtask

    task automatic send_px(input logic [7:0] d);
        send(1'b0, 1'b1, d);
    endtask

    task automatic send_blank();
        send(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_vs();
        send(1'b1, 1'b0, 8'h00);
    endtask

    task automatic send_line(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        send_px(b0);
        send_px(b1);
        send_px(b2);
        send_px(b3);
        send_blank();
    endtask

    task automatic expect_px(input logic sof, input logic eol, input logic [15:0] d);
        exp_q.push_back({sof, eol, d});
    endtask

    task automatic compare_px(input string tag);
        check($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_px%0d", tag, i),
                  (i < got_q.size()) ? 32'(got_q[i]) : 32'hxxxx_xxxx, 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        pxl_info = '0;
        pxl_vld  = 1'b0;
        start    = 1'b0;
        single   = 1'b0;
        err_clr  = 1'b0;
        rgb_rdy  = 1'b1;
        cycles(3);

        // Reset state
        @(negedge clk);
        check("rst_vld",   32'(rgb_vld),    32'd0);
        check("rst_pxl",   32'(rgb_pxl),    32'd0);
        check("rst_sof",   32'(rgb_sof),    32'd0);
        check("rst_eol",   32'(rgb_eol),    32'd0);
        check("rst_fdone", 32'(frame_done), 32'd0);
        check("rst_lerr",  32'(line_err),   32'd0);
        check("rst_ferr",  32'(frame_err),  32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_rdy",   32'(pxl_rdy),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycles(1);

        // 2x2 frame in continuous mode
        fd_base = fd_cnt;
        start = 1'b1;
        send_vs();
        send_line(8'hA5, 8'h3C, 8'h11, 8'h22);
        send_line(8'h33, 8'h44, 8'h55, 8'h66);
        send_vs();
        cycles(2);
        expect_px(1'b1, 1'b0, 16'hA53C);
        expect_px(1'b0, 1'b1, 16'h1122);
        expect_px(1'b0, 1'b0, 16'h3344);
        expect_px(1'b0, 1'b1, 16'h5566);
        compare_px("f1");
        check("f1_fdone", 32'(fd_cnt - fd_base), 32'd1);
        check("f1_lerr",  32'(line_err),  32'd0);
        check("f1_ferr",  32'(frame_err), 32'd0);
        check("f1_busy",  32'(busy),      32'd1);

        // Back-pressure for 10 cycles on the completing byte
        fd_base = fd_cnt;
        rgb_rdy = 1'b0;
        send_px(8'h77);
        send_px(8'h88);
        send_px(8'h99);
        pxl_info = {2'b01, 8'hAA};
        pxl_vld  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_rdy",  32'(pxl_rdy), 32'd0);
            check("stall_data", 32'(rgb_pxl), 32'h7788);
            check("stall_vld",  32'(rgb_vld), 32'd1);
        end
        @(posedge clk);
        #1;
        rgb_rdy = 1'b1;
        send_px(8'hAA);
        send_blank();
        send_line(8'hBB, 8'hCC, 8'hDD, 8'hEE);
        send_vs();
        cycles(2);
        expect_px(1'b1, 1'b0, 16'h7788);
        expect_px(1'b0, 1'b1, 16'h99AA);
        expect_px(1'b0, 1'b0, 16'hBBCC);
        expect_px(1'b0, 1'b1, 16'hDDEE);
        compare_px("f2");
        check("f2_fdone", 32'(fd_cnt - fd_base), 32'd1);
        check("f2_lerr",  32'(line_err), 32'd0);

        // Short line of 3 bytes, then a good line; start drops before the closing VSYNC
        send_px(8'h01);
        send_px(8'h02);
        send_px(8'h03);
        send_blank();
        check("f3_lerr_set", 32'(line_err),  32'd1);
        check("f3_ferr_mid", 32'(frame_err), 32'd0);
        send_line(8'h04, 8'h05, 8'h06, 8'h07);
        start = 1'b0;
        send_vs();
        cycles(2);
        check("f3_ferr",  32'(frame_err), 32'd0);
        check("f3_idle",  32'(busy),      32'd0);
        expect_px(1'b1, 1'b0, 16'h0102);
        expect_px(1'b0, 1'b0, 16'h0405);
        expect_px(1'b0, 1'b1, 16'h0607);
        compare_px("f3");
        clear_errors();
        check("f3_lerr_clr", 32'(line_err), 32'd0);

        // Single-frame mode: second frame is refused in DONE
        fd_base = fd_cnt;
        single = 1'b1;
        start  = 1'b1;
        send_vs();
        send_line(8'h10, 8'h20, 8'h30, 8'h40);
        send_line(8'h50, 8'h60, 8'h70, 8'h80);
        send_vs();
        pxl_info = {2'b10, 8'h00};
        pxl_vld  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("done_rdy",  32'(pxl_rdy), 32'd0);
            check("done_busy", 32'(busy),    32'd1);
        end
        @(posedge clk);
        #1;
        pxl_vld = 1'b0;
        start   = 1'b0;
        cycles(2);
        check("done_idle", 32'(busy), 32'd0);
        single = 1'b0;
        expect_px(1'b1, 1'b0, 16'h1020);
        expect_px(1'b0, 1'b1, 16'h3040);
        expect_px(1'b0, 1'b0, 16'h5060);
        expect_px(1'b0, 1'b1, 16'h7080);
        compare_px("sgl");
        check("sgl_fdone", 32'(fd_cnt - fd_base), 32'd1);

        // Byte before the first VSYNC is discarded; 3-line frame flags frame_err
        start = 1'b1;
        send_px(8'hFF);
        cycles(2);
        check("wvs_nopx", 32'(got_q.size()), 32'd0);
        send_vs();
        send_line(8'hA1, 8'hA2, 8'hA3, 8'hA4);
        send_line(8'hB1, 8'hB2, 8'hB3, 8'hB4);
        send_line(8'hC1, 8'hC2, 8'hC3, 8'hC4);
        start = 1'b0;
        send_vs();
        cycles(2);
        check("h3_ferr", 32'(frame_err), 32'd1);
        check("h3_lerr", 32'(line_err),  32'd0);
        expect_px(1'b1, 1'b0, 16'hA1A2);
        expect_px(1'b0, 1'b1, 16'hA3A4);
        expect_px(1'b0, 1'b0, 16'hB1B2);
        expect_px(1'b0, 1'b1, 16'hB3B4);
        expect_px(1'b0, 1'b0, 16'hC1C2);
        expect_px(1'b0, 1'b1, 16'hC3C4);
        compare_px("h3");
        clear_errors();
        check("h3_ferr_clr", 32'(frame_err), 32'd0);

        // Reset mid-line with a held pixel, then a clean restart
        start = 1'b1;
        send_vs();
        rgb_rdy = 1'b0;
        send_px(8'hC1);
        send_px(8'hC2);
        send_px(8'hC3);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mrst_vld",   32'(rgb_vld),    32'd0);
        check("mrst_pxl",   32'(rgb_pxl),    32'd0);
        check("mrst_sof",   32'(rgb_sof),    32'd0);
        check("mrst_eol",   32'(rgb_eol),    32'd0);
        check("mrst_fdone", 32'(frame_done), 32'd0);
        check("mrst_busy",  32'(busy),       32'd0);
        check("mrst_rdy",   32'(pxl_rdy),    32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        rgb_rdy = 1'b1;
        cycles(1);
        got_q.delete();
        start = 1'b1;
        send_vs();
        send_line(8'hD1, 8'hD2, 8'hD3, 8'hD4);
        send_line(8'hD5, 8'hD6, 8'hD7, 8'hD8);
        start = 1'b0;
        send_vs();
        cycles(2);
        expect_px(1'b1, 1'b0, 16'hD1D2);
        expect_px(1'b0, 1'b1, 16'hD3D4);
        expect_px(1'b0, 1'b0, 16'hD5D6);
        expect_px(1'b0, 1'b1, 16'hD7D8);
        compare_px("rs");
        check("rs_lerr", 32'(line_err),  32'd0);
        check("rs_ferr", 32'(frame_err), 32'd0);
        check("rs_idle", 32'(busy),      32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
